// File: rtl/dram_axi_bridge_pkg.sv
// dram_axi_bridge_pkg: AXI constants, bus types and FSM encoding shared by the DRAM-to-AXI bridge.
//   ID_W/LEN_W/SIZE_W/BURST_W/RESP_W : AXI field widths
//   SIZE_WORD, BURST_INCR, LEN_SINGLE : fixed per-transaction attribute values
//   state_e                           : bridge FSM states
//   resp_err()                        : maps an AXI response code to an error flag
package dram_axi_bridge_pkg;

    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [LEN_W-1:0]   LEN_SINGLE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR,
        ST_WR_B,
        ST_DONE
    } state_e;

    // SLVERR (10) and DECERR (11) both carry bit 1; EXOKAY (01) is not an error.
    function automatic logic resp_err(input logic [RESP_W-1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/dram_axi_bridge.sv
// dram_axi_bridge: turns the CPU's single-cycle data-RAM request into one AXI4 single-beat
// read or write, stalling the pipeline until the response returns.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_dram_*                  : CPU request (en, byte write enables, address, write data)
//   i_pipe_stall              : another stall source holds MEM; keeps the DONE result alive
//   o_dram_rdata, o_bus_err   : registered read data and 1-cycle error pulse, valid in DONE
//   o_stall                   : hold request toward PC..MEM
//   o_ar*/i_r*, o_aw*/o_w*/i_b* : AXI4 read and write channels (single outstanding beat)
module dram_axi_bridge
    import dram_axi_bridge_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     DATA_W   = 32,
    parameter logic [ID_W-1:0] AXI_ID   = 4'h1,
    parameter bit              RD_ALIGN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dram_en,
    input  logic [DATA_W/8-1:0]  i_dram_wen,
    input  logic [ADDR_W-1:0]    i_dram_addr,
    input  logic [DATA_W-1:0]    i_dram_wdata,
    input  logic                 i_pipe_stall,
    output logic [DATA_W-1:0]    o_dram_rdata,
    output logic                 o_stall,
    output logic                 o_bus_err,
    output logic [ID_W-1:0]      o_arid,
    output logic [ADDR_W-1:0]    o_araddr,
    output logic [LEN_W-1:0]     o_arlen,
    output logic [SIZE_W-1:0]    o_arsize,
    output logic [BURST_W-1:0]   o_arburst,
    output logic                 o_arvalid,
    input  logic                 i_arready,
    input  logic [ID_W-1:0]      i_rid,
    input  logic [DATA_W-1:0]    i_rdata,
    input  logic [RESP_W-1:0]    i_rresp,
    input  logic                 i_rlast,
    input  logic                 i_rvalid,
    output logic                 o_rready,
    output logic [ID_W-1:0]      o_awid,
    output logic [ADDR_W-1:0]    o_awaddr,
    output logic [LEN_W-1:0]     o_awlen,
    output logic [SIZE_W-1:0]    o_awsize,
    output logic [BURST_W-1:0]   o_awburst,
    output logic                 o_awvalid,
    input  logic                 i_awready,
    output logic [DATA_W-1:0]    o_wdata,
    output logic [DATA_W/8-1:0]  o_wstrb,
    output logic                 o_wlast,
    output logic                 o_wvalid,
    input  logic                 i_wready,
    input  logic [ID_W-1:0]      i_bid,
    input  logic [RESP_W-1:0]    i_bresp,
    input  logic                 i_bvalid,
    output logic                 o_bready
);

    state_e                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wen;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_bus_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_unused;

    assign w_aw_hs  = r_awvalid & i_awready;
    assign w_w_hs   = r_wvalid & i_wready;
    // A channel counts as finished if it handshook earlier or is handshaking now.
    assign w_aw_ok  = r_aw_done | w_aw_hs;
    assign w_w_ok   = r_w_done | w_w_hs;
    // IDs, rlast and the low response bit carry no information for single-beat traffic.
    assign w_unused = ^{i_rid, i_bid, i_rlast, i_rresp[0], i_bresp[0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= '0;
            r_rdata   <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_dram_en) begin
                        r_addr  <= i_dram_addr;
                        r_wdata <= i_dram_wdata;
                        r_wen   <= i_dram_wen;
                        if (i_dram_wen == '0) begin
                            r_state   <= ST_RD_A;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state   <= ST_WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end
                    end
                end
                ST_RD_A: begin
                    if (i_arready) begin
                        r_state   <= ST_RD_D;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                ST_RD_D: begin
                    if (i_rvalid) begin
                        r_state   <= ST_DONE;
                        r_rready  <= 1'b0;
                        r_rdata   <= i_rdata;
                        r_bus_err <= resp_err(i_rresp);
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= ST_WR_B;
                        r_bready <= 1'b1;
                    end
                end
                ST_WR_B: begin
                    if (i_bvalid) begin
                        r_state   <= ST_DONE;
                        r_bready  <= 1'b0;
                        r_bus_err <= resp_err(i_bresp);
                    end
                end
                ST_DONE: begin
                    // Error is a single pulse even if DONE is extended by pipe_stall.
                    r_bus_err <= 1'b0;
                    if (!i_pipe_stall)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by reset so the stall request is also forced low while reset is asserted.
    assign o_stall      = i_rst_n & ((r_state == ST_IDLE) ? i_dram_en : (r_state != ST_DONE));
    assign o_dram_rdata = r_rdata;
    assign o_bus_err    = r_bus_err;

    assign o_arid       = AXI_ID;
    assign o_araddr     = RD_ALIGN ? {r_addr[ADDR_W-1:2], 2'b00} : r_addr;
    assign o_arlen      = LEN_SINGLE;
    assign o_arsize     = SIZE_WORD;
    assign o_arburst    = BURST_INCR;
    assign o_arvalid    = r_arvalid;
    assign o_rready     = r_rready;

    assign o_awid       = AXI_ID;
    assign o_awaddr     = r_addr;
    assign o_awlen      = LEN_SINGLE;
    assign o_awsize     = SIZE_WORD;
    assign o_awburst    = BURST_INCR;
    assign o_awvalid    = r_awvalid;
    assign o_wdata      = r_wdata;
    assign o_wstrb      = r_wen;
    assign o_wlast      = 1'b1;
    assign o_wvalid     = r_wvalid;
    assign o_bready     = r_bready;

endmodule

// File: tb/tb_dram_axi_bridge.sv
// tb_dram_axi_bridge: cycle-by-cycle vector table plus hand-written reset sequences for dram_axi_bridge.
module tb_dram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ps;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic [31:0] dram_rdata;
    logic        stall, bus_err;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, axi_wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [3:0]  wstrb;
    logic        rlast;
    logic [6:0]  ctl;

    int n_cmp = 0;
    int n_err = 0;
    int cur   = -1;

    // sl = {arready, rvalid, awready, wready, bvalid}
    // xc = {stall, arvalid, rready, awvalid, wvalid, bready, bus_err}
    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ps;
        logic [4:0]  sl;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        logic [6:0]  xc;
        logic [31:0] xr;
        logic [31:0] xa;
        logic [31:0] xd;
        logic [3:0]  xs;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign rid   = 4'h7;
    assign bid   = 4'h9;
    assign rlast = 1'b1;
    assign ctl   = {stall, arvalid, rready, awvalid, wvalid, bready, bus_err};

    dram_axi_bridge dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dram_en(en), .i_dram_wen(wen), .i_dram_addr(addr), .i_dram_wdata(wdata),
        .i_pipe_stall(ps), .o_dram_rdata(dram_rdata), .o_stall(stall), .o_bus_err(bus_err),
        .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
        .o_arvalid(arvalid), .i_arready(arready),
        .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
        .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
        .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(axi_wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
        .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h, want %h", name, cur, act, exp);
        end
    endtask

    function automatic void add(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                                input logic p, input logic [4:0] s, input logic [31:0] r, input logic [1:0] rr,
                                input logic [1:0] br, input logic [6:0] xc, input logic [31:0] xr,
                                input logic [31:0] xa, input logic [31:0] xd, input logic [3:0] xs);
        vecs.push_back('{e, w, a, d, p, s, r, rr, br, xc, xr, xa, xd, xs});
    endfunction

    initial begin
        logic ok;
        int   n_ar;
        rst_n = 1'b0; en = 1'b0; wen = '0; addr = '0; wdata = '0; ps = 1'b0;
        {arready, rvalid, awready, wready, bvalid} = '0;
        rdata = '0; rresp = '0; bresp = '0;

        // Read 0x8000_0010, arready immediate, rvalid next cycle
        add(1, 4'h0, 32'h8000_0010, 0, 0, 5'b10000, 0,            0, 0, 7'b1000000, 0,            0,            0, 0);
        add(1, 4'h0, 32'h8000_0010, 0, 0, 5'b10000, 0,            0, 0, 7'b1100000, 0,            32'h8000_0010, 0, 0);
        add(1, 4'h0, 32'h8000_0010, 0, 0, 5'b11000, 32'h1234_5678, 0, 0, 7'b1010000, 0,            0,            0, 0);
        add(1, 4'h0, 32'h8000_0010, 0, 0, 5'b00000, 0,            0, 0, 7'b0000000, 32'h1234_5678, 0,            0, 0);
        add(0, 4'h0, 0,             0, 0, 5'b00000, 0,            0, 0, 7'b0000000, 32'h1234_5678, 0,            0, 0);
        // Write, wready first and awready two cycles later
        add(1, 4'h3, 32'h0000_0102, 32'hAABB_CCDD, 0, 5'b00000, 0, 0, 0, 7'b1000000, 32'h1234_5678, 0, 0, 0);
        add(1, 4'h3, 32'h0000_0102, 32'hAABB_CCDD, 0, 5'b00010, 0, 0, 0, 7'b1001100, 32'h1234_5678, 32'h0000_0102, 32'hAABB_CCDD, 4'h3);
        add(1, 4'h3, 32'h0000_0102, 32'hAABB_CCDD, 0, 5'b00000, 0, 0, 0, 7'b1001000, 32'h1234_5678, 32'h0000_0102, 0, 0);
        add(1, 4'h3, 32'h0000_0102, 32'hAABB_CCDD, 0, 5'b00100, 0, 0, 0, 7'b1001000, 32'h1234_5678, 32'h0000_0102, 0, 0);
        add(1, 4'h3, 32'h0000_0102, 32'hAABB_CCDD, 0, 5'b00001, 0, 0, 0, 7'b1000010, 32'h1234_5678, 0, 0, 0);
        add(1, 4'h3, 32'h0000_0102, 32'hAABB_CCDD, 0, 5'b00000, 0, 0, 0, 7'b0000000, 32'h1234_5678, 0, 0, 0);
        add(0, 4'h0, 0,             0,             0, 5'b00000, 0, 0, 0, 7'b0000000, 32'h1234_5678, 0, 0, 0);
        // Unaligned read with delayed arready, rvalid and SLVERR
        add(1, 4'h0, 32'h0000_0203, 0, 0, 5'b00000, 0,            0,     0, 7'b1000000, 32'h1234_5678, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0203, 0, 0, 5'b00000, 0,            0,     0, 7'b1100000, 32'h1234_5678, 32'h0000_0200, 0, 0);
        add(1, 4'h0, 32'h0000_0203, 0, 0, 5'b10000, 0,            0,     0, 7'b1100000, 32'h1234_5678, 32'h0000_0200, 0, 0);
        add(1, 4'h0, 32'h0000_0203, 0, 0, 5'b00000, 0,            0,     0, 7'b1010000, 32'h1234_5678, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0203, 0, 0, 5'b01000, 32'hDEAD_BEEF, 2'b10, 0, 7'b1010000, 32'h1234_5678, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0203, 0, 0, 5'b00000, 0,            0,     0, 7'b0000001, 32'hDEAD_BEEF, 0,            0, 0);
        add(0, 4'h0, 0,             0, 0, 5'b00000, 0,            0,     0, 7'b0000000, 32'hDEAD_BEEF, 0,            0, 0);
        // Read held in DONE by pipe_stall (stray rvalid ignored), then a write with awready first and DECERR
        add(1, 4'h0, 32'h0000_0010, 0, 0, 5'b00000, 0,            0, 0, 7'b1000000, 32'hDEAD_BEEF, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0010, 0, 0, 5'b10000, 0,            0, 0, 7'b1100000, 32'hDEAD_BEEF, 32'h0000_0010, 0, 0);
        add(1, 4'h0, 32'h0000_0010, 0, 0, 5'b01000, 32'hCAFE_F00D, 0, 0, 7'b1010000, 32'hDEAD_BEEF, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0010, 0, 1, 5'b00000, 0,            0, 0, 7'b0000000, 32'hCAFE_F00D, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0010, 0, 1, 5'b00000, 0,            0, 0, 7'b0000000, 32'hCAFE_F00D, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0010, 0, 1, 5'b01000, 32'h0BAD_BAD0, 0, 0, 7'b0000000, 32'hCAFE_F00D, 0,            0, 0);
        add(1, 4'h0, 32'h0000_0010, 0, 0, 5'b00000, 0,            0, 0, 7'b0000000, 32'hCAFE_F00D, 0,            0, 0);
        add(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 0, 5'b00000, 0, 0, 0,     7'b1000000, 32'hCAFE_F00D, 0, 0, 0);
        add(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 0, 5'b00100, 0, 0, 0,     7'b1001100, 32'hCAFE_F00D, 32'h0000_0020, 32'h1122_3344, 4'hF);
        add(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 0, 5'b00010, 0, 0, 0,     7'b1000100, 32'hCAFE_F00D, 0, 32'h1122_3344, 4'hF);
        add(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 0, 5'b00001, 0, 0, 2'b11, 7'b1000010, 32'hCAFE_F00D, 0, 0, 0);
        add(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 0, 5'b00000, 0, 0, 0,     7'b0000001, 32'hCAFE_F00D, 0, 0, 0);
        add(0, 4'h0, 0,             0,             0, 5'b00000, 0, 0, 0,     7'b0000000, 32'hCAFE_F00D, 0, 0, 0);

        // Reset state and fixed AXI attributes
        @(negedge clk);
        chk("reset_ctl", {25'd0, ctl}, 32'd0);
        chk("reset_rdata", dram_rdata, 32'd0);
        chk("ids", {24'd0, arid, awid}, 32'h11);
        chk("lens", {16'd0, arlen, awlen}, 32'd0);
        chk("size_burst_last", {21'd0, arsize, awsize, arburst, awburst, wlast}, {21'd0, 11'b010_010_01_01_1});
        #1 rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            cur = k;
            @(posedge clk);
            #1;
            en    = vecs[k].en;
            wen   = vecs[k].wen;
            addr  = vecs[k].addr;
            wdata = vecs[k].wdata;
            ps    = vecs[k].ps;
            {arready, rvalid, awready, wready, bvalid} = vecs[k].sl;
            rdata = vecs[k].rd;
            rresp = vecs[k].rr;
            bresp = vecs[k].br;
            @(negedge clk);
            chk("ctl", {25'd0, ctl}, {25'd0, vecs[k].xc});
            chk("rdata", dram_rdata, vecs[k].xr);
            if (vecs[k].xc[5]) chk("araddr", araddr, vecs[k].xa);
            if (vecs[k].xc[3]) chk("awaddr", awaddr, vecs[k].xa);
            if (vecs[k].xc[2]) begin
                chk("wdata", axi_wdata, vecs[k].xd);
                chk("wstrb", {28'd0, wstrb}, {28'd0, vecs[k].xs});
            end
        end

        // Asynchronous reset in the middle of a read data phase
        cur = 1000;
        @(posedge clk);
        #1;
        en = 1'b1; wen = 4'h0; addr = 32'h0000_0040; ps = 1'b0;
        {arready, rvalid, awready, wready, bvalid} = 5'b10000;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = rready;
        end
        chk("reach_rd_d", {31'd0, ok}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {25'd0, ctl}, 32'd0);
        chk("async_rst_rdata", dram_rdata, 32'd0);
        #3 rst_n = 1'b1;

        // A fresh read right after reset completes normally with a single AR
        cur = 1001;
        addr = 32'h0000_0044; rdata = 32'h5555_AAAA; rresp = 2'b00;
        {arready, rvalid, awready, wready, bvalid} = 5'b11000;
        ok = 1'b0;
        n_ar = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (arvalid) n_ar++;
            ok = !stall;
        end
        chk("post_rst_done", {31'd0, ok}, 32'd1);
        chk("post_rst_rdata", dram_rdata, 32'h5555_AAAA);
        chk("post_rst_ar_count", n_ar, 32'd1);
        @(posedge clk);
        #1;
        en = 1'b0;
        {arready, rvalid, awready, wready, bvalid} = '0;
        @(negedge clk);
        chk("final_idle_ctl", {25'd0, ctl}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
